// File: rtl/lpc_uart_target.sv
// lpc_uart_target: LPC I/O target exposing an 8-byte UART-style register window backed by RX/TX FIFOs
module lpc_uart_target #(
  parameter logic [15:0] BASE_ADDR = 16'h03F8,
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16,
  parameter int WAIT_MAX = 8
) (
  input  logic       lpc_clk,
  input  logic       lpc_rst,
  input  logic       lpc_frame,
  inout  wire  [3:0] lpc_data,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       irq
);
  localparam int RAW = $clog2(RX_DEPTH), TAW = $clog2(TX_DEPTH), RCW = RAW + 1, TCW = TAW + 1;
  typedef enum logic [3:0] {
    IDLE, CTDIR, ADDR0, ADDR1, ADDR2, ADDR3, WDATA0, WDATA1,
    HTAR0, HTAR1, SYNC, RDATA0, RDATA1, TTAR0, TTAR1
  } state_t;
  state_t state;
  logic is_wr, rd_pop, rx_ovf, oe;
  logic [11:0] addr;
  logic [2:0] ofs;
  logic [7:0] wdat, rdat, wait_cnt, rd_val;
  logic [3:0] lad_o, sync_nib;
  logic [7:0] rx_mem [RX_DEPTH];
  logic [7:0] tx_mem [TX_DEPTH];
  logic [RAW-1:0] rx_wp, rx_rp;
  logic [TAW-1:0] tx_wp, tx_rp;
  logic [RAW:0] rx_cnt;
  logic [TAW:0] tx_cnt;
  logic rx_full, tx_full, rx_push, rx_pop, tx_push, tx_pop, rx_flush, tx_flush, ovf_clr, sync_tx, wr_ctl;
  assign rx_full = rx_cnt == RCW'(RX_DEPTH);
  assign tx_full = tx_cnt == TCW'(TX_DEPTH);
  assign tx_valid = tx_cnt != '0;
  assign tx_data = tx_valid ? tx_mem[tx_rp] : 8'h00;
  assign irq = rx_cnt != '0 || rx_ovf;
  assign sync_tx = state == SYNC && is_wr && ofs == 3'd0;
  assign wr_ctl = state == SYNC && is_wr && ofs == 3'd2 && lpc_frame;
  assign sync_nib = !sync_tx || !tx_full ? 4'h0 : wait_cnt == 8'(WAIT_MAX) ? 4'hA : 4'h6;
  assign tx_push = sync_tx && !tx_full && lpc_frame;
  assign tx_pop = tx_valid && tx_ready;
  assign rx_push = rx_valid && !rx_full;
  assign rx_pop = state == RDATA1 && rd_pop && lpc_frame;
  assign ovf_clr = state == RDATA1 && ofs == 3'd1 && lpc_frame;
  assign rx_flush = wr_ctl && wdat[0];
  assign tx_flush = wr_ctl && wdat[1];
  assign oe = state inside {SYNC, RDATA0, RDATA1, TTAR0};
  assign lad_o = state == SYNC ? sync_nib : state == RDATA0 ? rdat[3:0] : state == RDATA1 ? rdat[7:4] : 4'hF;
  assign lpc_data = oe ? lad_o : 4'bz;
  assign rd_val = ofs == 3'd0 ? (rx_cnt != '0 ? rx_mem[rx_rp] : 8'h00) :
                  ofs == 3'd1 ? {1'b0, tx_cnt == '0, !tx_full, 3'b000, rx_ovf, rx_cnt != '0} :
                  ofs == 3'd2 ? 8'(rx_cnt) :
                  ofs == 3'd3 ? 8'(tx_cnt) : 8'hFF;
  always_ff @(posedge lpc_clk)
    if (!lpc_rst) begin
      state <= IDLE;
      is_wr <= 1'b0;
      rd_pop <= 1'b0;
      addr <= '0;
      ofs <= '0;
      wdat <= '0;
      rdat <= '0;
      wait_cnt <= '0;
    end else if (!lpc_frame) state <= lpc_data == 4'h0 ? CTDIR : IDLE;
    else case (state)
      CTDIR: begin
        is_wr <= lpc_data == 4'h2;
        state <= lpc_data == 4'h0 || lpc_data == 4'h2 ? ADDR0 : IDLE;
      end
      ADDR0: begin addr[11:8] <= lpc_data; state <= ADDR1; end
      ADDR1: begin addr[7:4] <= lpc_data; state <= ADDR2; end
      ADDR2: begin addr[3:0] <= lpc_data; state <= ADDR3; end
      ADDR3: begin
        ofs <= lpc_data[2:0];
        wait_cnt <= '0;
        state <= {addr, lpc_data[3]} != BASE_ADDR[15:3] ? IDLE : is_wr ? WDATA0 : HTAR0;
      end
      WDATA0: begin wdat[3:0] <= lpc_data; state <= WDATA1; end
      WDATA1: begin wdat[7:4] <= lpc_data; state <= HTAR0; end
      HTAR0: state <= HTAR1;
      HTAR1: state <= SYNC;
      SYNC: begin
        rdat <= rd_val;
        rd_pop <= ofs == 3'd0 && rx_cnt != '0;
        if (sync_nib == 4'h6) wait_cnt <= wait_cnt + 8'd1;
        else state <= is_wr ? TTAR0 : RDATA0;
      end
      RDATA0: state <= RDATA1;
      RDATA1: state <= TTAR0;
      TTAR0: state <= TTAR1;
      default: state <= IDLE;
    endcase
  always_ff @(posedge lpc_clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_data;
    if (tx_push) tx_mem[tx_wp] <= wdat;
  end
  always_ff @(posedge lpc_clk) begin
    if (!lpc_rst || rx_flush) begin
      rx_wp <= '0;
      rx_rp <= '0;
      rx_cnt <= '0;
      rx_ovf <= 1'b0;
    end else begin
      rx_wp <= rx_wp + RAW'(rx_push);
      rx_rp <= rx_rp + RAW'(rx_pop);
      rx_cnt <= rx_cnt + RCW'(rx_push) - RCW'(rx_pop);
      rx_ovf <= (rx_valid && rx_full) || (rx_ovf && !ovf_clr);
    end
    if (!lpc_rst || tx_flush) begin
      tx_wp <= '0;
      tx_rp <= '0;
      tx_cnt <= '0;
    end else begin
      tx_wp <= tx_wp + TAW'(tx_push);
      tx_rp <= tx_rp + TAW'(tx_pop);
      tx_cnt <= tx_cnt + TCW'(tx_push) - TCW'(tx_pop);
    end
  end
endmodule
